// File: rtl/rf_wb_sched.sv
// rf_wb_sched: round-robin write-back arbiter, busy scoreboard and drain FSM for the register file.
module rf_wb_sched #(
    parameter int WIDTH   = 128,
    parameter int REGBITS = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iss_valid,
    input  logic [REGBITS-1:0] iss_ra1,
    input  logic [REGBITS-1:0] iss_ra2,
    input  logic [REGBITS-1:0] iss_rt,
    input  logic               iss_wr,
    output logic               iss_stall,
    input  logic               e_valid,
    input  logic               o_valid,
    input  logic               i_valid,
    input  logic [REGBITS-1:0] e_wa,
    input  logic [REGBITS-1:0] o_wa,
    input  logic [REGBITS-1:0] i_wa,
    input  logic [WIDTH-1:0]   e_wd,
    input  logic [WIDTH-1:0]   o_wd,
    input  logic [WIDTH-1:0]   i_wd,
    output logic               e_ready,
    output logic               o_ready,
    output logic               i_ready,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    input  logic               flush_req,
    output logic               flush_done,
    output logic [REGBITS:0]   pend_cnt,
    output logic               wb_err
);
    localparam int NREG = 2**REGBITS;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             r_state, w_next;
    logic [NREG-1:0]    r_busy;
    logic [1:0]         r_rr;
    logic [REGBITS:0]   r_pend;
    logic               r_regwrite, r_err;
    logic [REGBITS-1:0] r_wa;
    logic [WIDTH-1:0]   r_wd;
    logic [2:0]         w_g;
    logic               w_xfer, w_hit, w_clr, w_set, w_drain, w_idle;
    logic [REGBITS-1:0] w_twa;
    logic [WIDTH-1:0]   w_twd;
    logic [1:0]         w_nrr;

    // r_rr names the source with top priority: 0=E, 1=O, 2=I
    assign w_g[0] = e_valid & (r_rr == 2'd0 | (r_rr == 2'd1 & ~o_valid & ~i_valid) | (r_rr == 2'd2 & ~i_valid));
    assign w_g[1] = o_valid & (r_rr == 2'd1 | (r_rr == 2'd2 & ~i_valid & ~e_valid) | (r_rr == 2'd0 & ~e_valid));
    assign w_g[2] = i_valid & (r_rr == 2'd2 | (r_rr == 2'd0 & ~e_valid & ~o_valid) | (r_rr == 2'd1 & ~o_valid));
    assign {i_ready, o_ready, e_ready} = w_g;

    assign w_xfer  = |w_g;
    assign w_twa   = w_g[0] ? e_wa : w_g[1] ? o_wa : i_wa;
    assign w_twd   = w_g[0] ? e_wd : w_g[1] ? o_wd : i_wd;
    assign w_nrr   = w_g[0] ? 2'd1 : w_g[1] ? 2'd2 : 2'd0;
    assign w_hit   = r_busy[w_twa];
    assign w_clr   = w_xfer & w_hit;
    assign w_drain = r_state == DRAIN;
    assign w_idle  = r_pend == '0 & ~r_regwrite;

    assign iss_stall = iss_valid & (r_busy[iss_ra1] | r_busy[iss_ra2] | (iss_wr & r_busy[iss_rt]) | w_drain);
    // a set needs the bit clear and a clear needs it set, so both never hit the same register
    assign w_set     = iss_valid & ~iss_stall & iss_wr;

    assign regwrite = r_regwrite;
    assign wa       = r_wa;
    assign wd       = r_wd;
    assign pend_cnt = r_pend;
    assign wb_err   = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy     <= '0;
            r_rr       <= 2'd0;
            r_pend     <= '0;
            r_regwrite <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_clr) r_busy[w_twa] <= 1'b0;
            if (w_set) r_busy[iss_rt] <= 1'b1;
            if (w_xfer) r_rr <= w_nrr;
            if (w_xfer) r_wa <= w_twa;
            if (w_xfer) r_wd <= w_twd;
            if (w_xfer & ~w_hit) r_err <= 1'b1;
            r_regwrite <= w_xfer;
            r_pend     <= r_pend + {{REGBITS{1'b0}}, w_set} - {{REGBITS{1'b0}}, w_clr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == RUN ? (flush_req ? DRAIN : RUN) : (w_idle ? RUN : DRAIN);
    end

    always_comb begin
        flush_done = w_drain & w_idle;
    end
endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-back scheduler and hazard scoreboard for the SPU 128x128 register file.
- The register file has one write port. Three producers share it: the even pipe, the odd pipe and the immediate-load path. This block arbitrates them round-robin and drives the regwrite/wa/wd port.
- It keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
- A flush FSM drains all pending writes before a context switch.

Parameters:
- WIDTH, 128, data width of a register and of all write-data buses.
- REGBITS, 7, register address width; NREG = 2**REGBITS registers.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iss_valid  in  1  issue stage presents an instruction.
- iss_ra1  in  REGBITS  source register 1.
- iss_ra2  in  REGBITS  source register 2.
- iss_rt  in  REGBITS  target register.
- iss_wr  in  1  instruction writes iss_rt.
- iss_stall  out  1  combinational; instruction not accepted this cycle.
- e_valid, o_valid, i_valid  in  1 each  write-back request from even, odd, immediate source.
- e_wa, o_wa, i_wa  in  REGBITS each  request target register.
- e_wd, o_wd, i_wd  in  WIDTH each  request data.
- e_ready, o_ready, i_ready  out  1 each  combinational grant; transfer = valid & ready.
- regwrite  out  1  registered write enable to the register file.
- wa  out  REGBITS  registered write address.
- wd  out  WIDTH  registered write data.
- flush_req  in  1  request drain; level, sampled in RUN.
- flush_done  out  1  one-cycle pulse when drain completes.
- pend_cnt  out  REGBITS+1  number of busy registers.
- wb_err  out  1  sticky; write-back to a register that was not busy.

Behaviour:
- Reset (async, on reset high): regwrite=0, wa=0, wd=0, busy[]=all 0, pend_cnt=0, rr pointer=E, state=RUN, flush_done=0, wb_err=0.
- Arbitration:
  - Static order E,O,I rotated by rr pointer; the highest-priority valid source gets ready=1. At most one ready per cycle.
  - On a transfer, rr pointer = winner+1 mod 3 (E->O->I->E). With no transfer the pointer holds.
  - Arbitration runs in both RUN and DRAIN.
- Write port latency is 1: a transfer at edge N gives regwrite=1 with wa/wd = winner's wa/wd during cycle N..N+1. With no transfer, regwrite=0 and wa/wd hold their last values.
- Scoreboard:
  - busy[wa] clears at the transfer edge.
  - If the target register was not busy: wb_err is set (sticky until reset) and the write still proceeds.
- Issue:
  - iss_stall = iss_valid & (busy[iss_ra1] | busy[iss_ra2] | (iss_wr & busy[iss_rt]) | state==DRAIN).
  - Accept = iss_valid & ~iss_stall. If iss_wr, busy[iss_rt] is set at that edge.
- Simultaneous events:
  - Clear of X and issue reading X in the same cycle: busy[X] is still 1 that cycle, so the issue stalls and is accepted next cycle. This guarantees no set and clear of the same bit in one cycle.
  - Set of X and clear of Y≠X in the same edge: both happen.
- pend_cnt: +1 on accepted iss_wr, -1 on a transfer that clears a busy bit. Both in the same cycle = unchanged. Never wraps; max NREG.
- FSM:
  - RUN: flush_req=1 -> DRAIN.
  - DRAIN: issue is blocked. When pend_cnt==0 and regwrite==0 -> flush_done=1 for one cycle and return to RUN. flush_req is ignored while in DRAIN.
- Reset mid-operation returns to the reset values immediately. In-flight requests are dropped and regwrite drops asynchronously.

Test Plan:
- Reset mid-stream: assert reset while regwrite=1 and pend_cnt=3 -> regwrite=0, pend_cnt=0, state RUN, iss_stall=0 for a hazard-free issue, all in the same cycle.
- Issue iss_wr=1, iss_rt=5, then iss_ra1=5 next cycle -> iss_stall=1. Then e_valid, e_wa=5, e_wd=0xA5 -> e_ready=1. Next cycle regwrite=1, wa=5, wd=0xA5, and the stalled issue is accepted one cycle after the transfer. pend_cnt 1->0.
- E, O, I all valid continuously, targets 1, 2, 3 each pre-busied -> grants E,O,I,E,O,I on consecutive cycles. regwrite=1 every cycle.
- Issue to rt=7 while 7 is busy (WAW) -> iss_stall=1 until the write-back of 7 transfers.
- o_valid to wa=9 with busy[9]=0 -> write occurs (regwrite=1, wa=9) and wb_err=1 stays set.
- 3 writes pending, pulse flush_req -> issue stalled. After the third transfer plus one cycle, flush_done pulses once and state returns to RUN.
